// File: rtl/quad_serial_adder_pkg.sv
// quad_serial_adder_pkg: shared widths and the controller state type for the
// digit-serial 64-bit adder.
package quad_serial_adder_pkg;

  localparam int DATA_W     = 64;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = DATA_W / DIGIT_W;
  localparam int CNT_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/quad_serial_adder_nibble_adder.sv
// nibble_adder: combinational W-bit ripple-carry adder with carry in and out.
// One instance handles a single digit per clock inside quad_serial_adder.
module nibble_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic c;

  // Ripple the carry bit by bit from the LSB upwards.
  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/quad_serial_adder.sv
// quad_serial_adder: digit-serial unsigned adder, one DIGIT_W-bit digit per
// clock. Operands are captured on the first edge where start is seen low
// after being armed; done/result/carryOut update on the FIN edge 17 cycles
// later.
// Optional build macro QSA_DONE_PULSE_EN: done becomes a one-cycle pulse
// instead of a level held until the next start.
module quad_serial_adder
  import quad_serial_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dA,
  input  logic [DATA_W-1:0] dB,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carryOut
);

  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t              state;
  logic [DATA_W-1:0]   a_sr;
  logic [DATA_W-1:0]   b_sr;
  logic [DATA_W-1:0]   s_sr;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [DIGIT_W-1:0]  nib_sum;
  logic                nib_cout;

  nibble_adder #(
    .W(DIGIT_W)
  ) u_nibble_adder (
    .a    (a_sr[DIGIT_W-1:0]),
    .b    (b_sr[DIGIT_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Controller and datapath: arm on start, capture on release, shift one
  // digit per edge, then publish the sum on the FIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carryOut <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef QSA_DONE_PULSE_EN
          done <= 1'b0;
`endif
          if (start) begin
            done  <= 1'b0;
            state <= ARM;
          end
        end
        ARM: begin
          if (!start) begin
            a_sr  <= dA;
            b_sr  <= dB;
            carry <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          a_sr  <= a_sr >> DIGIT_W;
          b_sr  <= b_sr >> DIGIT_W;
          s_sr  <= {nib_sum, s_sr[DATA_W-1:DIGIT_W]};
          carry <= nib_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_DIGIT) begin
            state <= FIN;
          end
        end
        FIN: begin
          result   <= s_sr;
          carryOut <= carry;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_serial_adder.sv
// tb_quad_serial_adder: drives directed and random additions into
// quad_serial_adder and compares against 65-bit arithmetic in the bench.
module tb_quad_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dA;
  logic [63:0] dB;
  logic        done;
  logic [63:0] result;
  logic        carryOut;

  int          checkCount;
  int          errorCount;
  logic [63:0] prevResult;
  logic        prevCarry;

  quad_serial_adder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dA       (dA),
    .dB       (dB),
    .done     (done),
    .result   (result),
    .carryOut (carryOut)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it when observed and required differ.
  task automatic checkOutput(input string tag, input logic [64:0] actual,
                             input logic [64:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Run one addition: hold start for startHigh edges, release with the
  // operands, optionally poke start mid-ADD, and check the timing of done.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input int startHigh, input bit pokeStart,
                               input string tag);
    logic [64:0] full;
    full = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    start = 1'b1;
    dA = rand64();
    dB = rand64();
    for (int i = 0; i < startHigh; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput({tag, ".doneClearedOnStart"}, 65'(done), 65'd0);
    end
    start = 1'b0;
    dA = a;
    dB = b;
    @(negedge clk);
    dA = rand64();
    dB = rand64();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (pokeStart && k == 5) start = 1'b1;
      if (pokeStart && k == 7) start = 1'b0;
      if (k == 16) begin
        checkOutput({tag, ".doneBeforeFin"}, 65'(done), 65'd0);
        checkOutput({tag, ".resultHeld"}, {prevCarry, prevResult}, {carryOut, result});
      end
    end
    @(negedge clk);
    checkOutput({tag, ".done"}, 65'(done), 65'd1);
    checkOutput({tag, ".sum"}, {carryOut, result}, full);
    prevResult = full[63:0];
    prevCarry  = full[64];
    @(negedge clk);
`ifdef QSA_DONE_PULSE_EN
    checkOutput({tag, ".donePulseEnds"}, 65'(done), 65'd0);
`else
    checkOutput({tag, ".doneLevelHeld"}, 65'(done), 65'd1);
`endif
    checkOutput({tag, ".sumStillHeld"}, {carryOut, result}, full);
  endtask

  // Start an add, then reset halfway through the digit loop.
  task automatic resetMidAdd();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dA = 64'hFFFF_FFFF_FFFF_FFFF;
    dB = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("midReset.done", 65'(done), 65'd0);
    checkOutput("midReset.outputs", {carryOut, result}, 65'd0);
    rst = 1'b0;
    start = 1'b0;
    prevResult = '0;
    prevCarry  = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midReset.staysIdle", {done, carryOut, result[62:0]}, 65'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    checkCount = 0;
    errorCount = 0;
    prevResult = '0;
    prevCarry  = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    dA    = '0;
    dB    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.done", 65'(done), 65'd0);
    checkOutput("reset.outputs", {carryOut, result}, 65'd0);
    rst = 1'b0;
    dA = rand64();
    dB = rand64();
    repeat (5) @(negedge clk);
    checkOutput("idle.noActivity", {done, carryOut, result[62:0]}, 65'd0);

    applyStimulus(64'h17, 64'h0F, 2, 1'b0, "small");
    applyStimulus(64'h0000435567000009, 64'h0012345790000005, 1, 1'b0, "mixed");
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'h1, 3, 1'b0, "ripple");
    applyStimulus(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1, 1'b1, "pokeStart");
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2, 1'b0, "maxBoth");
    applyStimulus(64'h0, 64'h0, 1, 1'b0, "zero");

    resetMidAdd();
    applyStimulus(64'h8000000000000000, 64'h8000000000000000, 1, 1'b0, "afterReset");

    for (int n = 0; n < 8; n++) begin
      ra = rand64();
      rb = rand64();
      if (n == 3) rb = ~ra;
      if (n == 5) rb = (~ra) + 64'd1;
      applyStimulus(ra, rb, 1 + int'($urandom_range(0, 2)), n[0], $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
